// File: rtl/otter_intr_pkg.sv
`timescale 1ns / 1ps
// otter_intr_pkg
// Shared types and constants for the OTTER interrupt request controller.
//   db_state_t  : debounce FSM states (LO, RISE, HI, FALL)
//   SYNC_STAGES : depth of the btn_raw metastability synchronizer
package otter_intr_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    LO   = 2'd0,
    RISE = 2'd1,
    HI   = 2'd2,
    FALL = 2'd3
  } db_state_t;

endpackage

// File: rtl/otter_debounce.sv
`timescale 1ns / 1ps
// otter_debounce
// Two-flop synchronizer followed by a debounce FSM. A level change on the
// synchronized button is accepted only after DB_CYCLES consecutive stable
// cycles. An accepted rising change raises btn_db and pulses press for one
// cycle; an accepted falling change only lowers btn_db.
//
// Ports
//   clk     in  : system clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   btn_raw in  : raw asynchronous button level
//   btn_db  out : debounced level (registered)
//   press   out : one-cycle pulse on each accepted press (registered)
//   state   out : current FSM state, for observation
module otter_debounce
  import otter_intr_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      btn_raw,
  output logic      btn_db,
  output logic      press,
  output db_state_t state
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW:0]   DB_LIM  = (CW + 1)'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  logic [CW-1:0]          cnt;
  logic [CW:0]            cnt_inc;
  logic                   done;

  assign s2      = sync[SYNC_STAGES-1];
  // One bit wider than cnt so the increment can never wrap before compare.
  assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);
  // Decided on the incremented value so the change is accepted on the edge
  // where the count reaches DB_CYCLES (DB_CYCLES=1 finishes in the first
  // RISE/FALL cycle).
  assign done    = (cnt_inc >= DB_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      state  <= LO;
      cnt    <= '0;
      btn_db <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn_raw};
      press <= 1'b0;
      case (state)
        LO: begin
          if (s2) begin
            state <= RISE;
            cnt   <= CNT_ONE;
          end
        end
        RISE: begin
          if (!s2) begin
            state <= LO;
            cnt   <= '0;
          end else if (done) begin
            state  <= HI;
            cnt    <= '0;
            btn_db <= 1'b1;
            press  <= 1'b1;
          end else begin
            cnt <= cnt_inc[CW-1:0];
          end
        end
        HI: begin
          if (!s2) begin
            state <= FALL;
            cnt   <= CNT_ONE;
          end
        end
        FALL: begin
          if (s2) begin
            state <= HI;
            cnt   <= '0;
          end else if (done) begin
            state  <= LO;
            cnt    <= '0;
            btn_db <= 1'b0;
          end else begin
            cnt <= cnt_inc[CW-1:0];
          end
        end
        default: begin
          state <= LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/otter_intr_ctrl.sv
`timescale 1ns / 1ps
// otter_intr_ctrl
// Turns debounced presses of the board interrupt button into a sticky
// pending request for the OTTER CPU and holds it until the CPU acknowledges.
//
// Ports
//   clk        in  : system clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   btn_raw    in  : raw asynchronous button level
//   intr_en    in  : CPU interrupt enable (MIE), masks intr only
//   intr_ack   in  : one-cycle pulse when the CPU takes the trap
//   intr       out : pending & intr_en (combinational)
//   pending    out : registered sticky request flag
//   btn_db     out : debounced button level
//   missed_cnt out : saturating count of presses that arrived while pending
//
// Configuration
//   OTTER_INTR_MISSED_CNT_EN : when defined, missed_cnt counter is built;
//                              otherwise missed_cnt is tied to 0.
//
// Handshake: intr is a level request; it stays high until the CPU returns a
// single-cycle intr_ack. The ack clears pending on that edge unless a new
// press lands on the same edge, in which case the new event keeps pending set.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic             intr_en,
  input  logic             intr_ack,
  output logic             intr,
  output logic             pending,
  output logic             btn_db,
  output logic [CNT_W-1:0] missed_cnt
);

  logic      press;
  db_state_t db_state;

  otter_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .btn_db (btn_db),
    .press  (press),
    .state  (db_state)
  );

  // A press has priority over an ack on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (press) begin
      pending <= 1'b1;
    end else if (intr_ack) begin
      pending <= 1'b0;
    end
  end

`ifdef OTTER_INTR_MISSED_CNT_EN
  // A press colliding with an ack replaces the acknowledged request rather
  // than being lost, so it is not counted as missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missed_cnt <= '0;
    end else if (press && pending && !intr_ack && (missed_cnt != '1)) begin
      missed_cnt <= missed_cnt + CNT_W'(1);
    end
  end
`else
  assign missed_cnt = '0;
`endif

  assign intr = pending & intr_en;

  // btn_db is high exactly in the states that follow an accepted rise.
  a_btn_db_state: assert property (@(posedge clk) disable iff (!rst_n)
    btn_db == ((db_state == HI) || (db_state == FALL)));

endmodule

// File: doc/otter_intr_ctrl.md
# otter_intr_ctrl

Interrupt request controller between the board interrupt button and the OTTER CPU interrupt input. Synchronizes and debounces the raw button, turns each debounced press into a sticky pending request, and holds that request until the CPU acknowledges taking the trap. Sits inside the OTTER wrapper, between `buttons[4]` and the CPU `intr` pin.

## Interface
- `DB_CYCLES`, default 1_000_000: number of consecutive stable synchronized cycles required to accept a level change. Legal range ≥1.
- `CNT_W`, default 8: width of the missed-press counter.

- `clk` in 1: system clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_raw` in 1: raw, asynchronous, bouncing button level.
- `intr_en` in 1: CPU interrupt enable (the MIE CSR bit), level.
- `intr_ack` in 1: one-cycle pulse from the CPU on the cycle it takes the interrupt trap.
- `intr` out 1: interrupt request to the CPU, `pending & intr_en`, combinational.
- `pending` out 1: registered sticky request flag.
- `btn_db` out 1: debounced button level, registered.
- `missed_cnt` out CNT_W: presses accepted while `pending` was already set, saturating.

## Operation
- **Synchronizer:** `btn_raw` passes through 2 flops (`s1`, `s2`). Only `s2` is used downstream.
- **Debounce FSM** (state register, plus a `$clog2(DB_CYCLES+1)`-bit counter `cnt`):
  - `LO`: `btn_db`=0. If `s2`=1, go to `RISE` with `cnt`=1.
  - `RISE`: if `s2`=0, return to `LO` with `cnt`=0. Otherwise `cnt`++. When `cnt` reaches DB_CYCLES, go to `HI`, set `btn_db`=1 and pulse internal `press` for 1 cycle.
  - `HI`: `btn_db`=1. If `s2`=0, go to `FALL` with `cnt`=1.
  - `FALL`: mirror of `RISE`. Return to `HI` if `s2`=1. On `cnt`==DB_CYCLES, go to `LO` and set `btn_db`=0. No pulse on release.
  - DB_CYCLES=1 is legal: the transition completes in the first cycle of `RISE`/`FALL`.
- **Pending latch**, evaluated each cycle:
  - `press` is set: `pending`←1. If `pending` was already 1, `missed_cnt`++ (saturates at 2^CNT_W−1).
  - else `intr_ack`: `pending`←0.
  - Simultaneous `press` and `intr_ack`: `pending` stays 1, because the new event wins. `missed_cnt` does not increment in this case.
  - `intr_ack` while `pending`=0 is ignored.
- `intr_en`=0 masks `intr` only. Presses are still latched into `pending`.
- **Reset** (async, any time, including mid-debounce):
  - `s1`=`s2`=0, state `LO`, `cnt`=0.
  - `btn_db`=0, `pending`=0, `intr`=0, `missed_cnt`=0.
  - A button held through reset release is accepted as a new press after the full debounce.

## Timing
- Let edge k be the first edge that samples `btn_raw`=1.
  - `s2`=1 after edge k+1.
  - `btn_db`=1 and `press` after edge k+1+DB_CYCLES.
  - `pending`=1 after edge k+2+DB_CYCLES.
  - Total latency is DB_CYCLES+2 cycles.
- `intr` follows `pending` and `intr_en` in the same cycle (combinational AND).
- `intr_ack` sampled at edge j: `pending`=0 and `intr`=0 after edge j.
- A bounce shorter than DB_CYCLES synchronized cycles produces no state change beyond `RISE`/`FALL`.

## Configuration
- Macro: `OTTER_INTR_MISSED_CNT_EN`.
- Defined: `missed_cnt` counter built as specified.
- Undefined: no counter logic; `missed_cnt` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `otter_intr_pkg`:
  - enum `db_state_t` {`LO`, `RISE`, `HI`, `FALL`}.
  - constant `SYNC_STAGES`=2.
- Sub-module `otter_debounce`: synchronizer plus FSM, outputs `btn_db` and `press`.
- The top level holds the pending latch, the missed counter and the `intr` gating.

## Test plan
All scenarios use DB_CYCLES=4, CNT_W=8 and a 10 ns clk.
- **Reset:** `rst_n`=0 asynchronously mid-cycle → `intr`, `pending`, `btn_db`, `missed_cnt` all 0 immediately; all stay 0 for 5 cycles after release with `btn_raw`=0.
- **Clean press:** `intr_en`=1, `btn_raw`=1 for 10 cycles → `intr`=1 exactly 6 edges after the first sample; `intr` holds until a 1-cycle `intr_ack`, then 0 the next cycle. Release produces no new `pending`.
- **Glitch:** `btn_raw` high for 3 cycles, then low → `btn_db`, `pending` and `intr` remain 0 throughout.
- **Masking:** `intr_en`=0 and a press → `pending`=1, `intr`=0. Raise `intr_en` → `intr`=1 in the same cycle.
- **Overflow and collision:**
  - Second press while `pending`=1 → `missed_cnt`=1 and `pending` stays 1.
  - `intr_ack` coincident with `press` → `pending` stays 1 and `missed_cnt` is unchanged.
- **Reset mid-debounce:** assert `rst_n`=0 during `RISE` at `cnt`=2 with `btn_raw` held 1 → after release, `pending`=1 only 6 cycles later.
